// File: rtl/prbs_frame_ctrl_if.sv
// rtl/prbs_frame_ctrl_if.sv - byte stream handshake bundle for the PRBS frame sequencer
interface prbs_frame_ctrl_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/prbs_frame_ctrl.sv
// rtl/prbs_frame_ctrl.sv - sync header + PRBS15 payload frame sequencer (optional checksum: PRBS_FRAME_CHK_EN)
module prbs_frame_ctrl #(
    parameter logic [31:0] PATTERN = 32'hAABBCCDD,
    parameter logic [14:0] SEED    = 15'h7FFF
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [7:0]                sync_reps,
    input  logic [15:0]               payload_len,
    prbs_frame_ctrl_if.master         stream,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD,
`ifdef PRBS_FRAME_CHK_EN
        ST_CHK,
`endif
        ST_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  rep_cnt_q, rep_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [7:0]  reps_q, reps_d;
    logic [15:0] len_q, len_d;
    logic [14:0] lfsr_q, lfsr_d;
`ifdef PRBS_FRAME_CHK_EN
    logic [7:0]  acc_q, acc_d;
`endif

    logic        accept;
    logic [14:0] lfsr_src;
    logic [7:0]  prbs_byte;
    logic [14:0] prbs_next;

    // Eight serial LFSR steps; the first feedback bit lands in the byte MSB.
    function automatic logic [22:0] prbs_step8(input logic [14:0] s_in);
        logic [14:0] s;
        logic [7:0]  b;
        logic        fb;
        s = s_in;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            fb = s[14] ^ s[13];
            s  = {s[13:0], fb};
            b  = {b[6:0], fb};
        end
        return {b, s};
    endfunction

    function automatic logic [7:0] pat_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    pat_byte = PATTERN[31:24];
            2'd1:    pat_byte = PATTERN[23:16];
            2'd2:    pat_byte = PATTERN[15:8];
            default: pat_byte = PATTERN[7:0];
        endcase
    endfunction

    // lfsr_q holds the state after the byte currently presented, so one
    // 8-step network serves both the frame's first payload byte and every later one.
    assign accept   = out_valid_q && stream.out_ready;
    assign lfsr_src = (state_q == ST_IDLE) ? SEED : lfsr_q;
    assign {prbs_byte, prbs_next} = prbs_step8(lfsr_src);

    // State register and all registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            byte_idx_q  <= '0;
            rep_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            reps_q      <= '0;
            len_q       <= '0;
            lfsr_q      <= SEED;
`ifdef PRBS_FRAME_CHK_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            byte_idx_q  <= byte_idx_d;
            rep_cnt_q   <= rep_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            reps_q      <= reps_d;
            len_q       <= len_d;
            lfsr_q      <= lfsr_d;
`ifdef PRBS_FRAME_CHK_EN
            acc_q       <= acc_d;
`endif
        end
    end

    // Next-state and next-output logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        byte_idx_d  = byte_idx_q;
        rep_cnt_d   = rep_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        reps_d      = reps_q;
        len_d       = len_q;
        lfsr_d      = lfsr_q;
`ifdef PRBS_FRAME_CHK_EN
        acc_d       = acc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                if (start && !abort) begin
                    reps_d     = sync_reps;
                    len_d      = payload_len;
                    lfsr_d     = SEED;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                    rep_cnt_d  = '0;
                    pay_cnt_d  = '0;
`ifdef PRBS_FRAME_CHK_EN
                    acc_d      = '0;
`endif
                    if (sync_reps != 8'd0) begin
                        state_d     = ST_SYNC;
                        out_data_d  = pat_byte(2'd0);
                        out_valid_d = 1'b1;
                    end else if (payload_len != 16'd0) begin
                        state_d     = ST_PAYLOAD;
                        out_data_d  = prbs_byte;
                        lfsr_d      = prbs_next;
                        out_valid_d = 1'b1;
                    end else begin
`ifdef PRBS_FRAME_CHK_EN
                        state_d     = ST_CHK;
                        out_data_d  = 8'h00;
                        out_valid_d = 1'b1;
`else
                        state_d     = ST_FINISH;
`endif
                    end
                end
            end

            ST_SYNC: begin
                if (accept) begin
                    if (byte_idx_q == 2'd3) begin
                        byte_idx_d = '0;
                        if (rep_cnt_q == reps_q - 8'd1) begin
                            if (len_q != 16'd0) begin
                                state_d    = ST_PAYLOAD;
                                out_data_d = prbs_byte;
                                lfsr_d     = prbs_next;
                            end else begin
`ifdef PRBS_FRAME_CHK_EN
                                state_d     = ST_CHK;
                                out_data_d  = acc_q;
`else
                                state_d     = ST_FINISH;
                                out_valid_d = 1'b0;
`endif
                            end
                        end else begin
                            rep_cnt_d  = rep_cnt_q + 8'd1;
                            out_data_d = pat_byte(2'd0);
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        out_data_d = pat_byte(byte_idx_q + 2'd1);
                    end
                end
            end

            ST_PAYLOAD: begin
                if (accept) begin
`ifdef PRBS_FRAME_CHK_EN
                    acc_d = acc_q ^ out_data_q;
`endif
                    if (pay_cnt_q == len_q - 16'd1) begin
`ifdef PRBS_FRAME_CHK_EN
                        state_d    = ST_CHK;
                        out_data_d = acc_q ^ out_data_q;
`else
                        state_d     = ST_FINISH;
                        out_valid_d = 1'b0;
`endif
                    end else begin
                        pay_cnt_d  = pay_cnt_q + 16'd1;
                        out_data_d = prbs_byte;
                        lfsr_d     = prbs_next;
                    end
                end
            end

`ifdef PRBS_FRAME_CHK_EN
            ST_CHK: begin
                if (accept) begin
                    state_d     = ST_FINISH;
                    out_valid_d = 1'b0;
                end
            end
`endif

            // Two cycles: first raises done, second drops busy and returns to IDLE.
            ST_FINISH: begin
                out_valid_d = 1'b0;
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
`ifdef PRBS_FRAME_CHK_EN
            acc_d       = '0;
`endif
        end
    end

    assign stream.out_data  = out_data_q;
    assign stream.out_valid = out_valid_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// tb/tb_prbs_frame_ctrl.sv - randomized self-checking bench for prbs_frame_ctrl
module tb_prbs_frame_ctrl;

    localparam bit [31:0] PAT = 32'hAABBCCDD;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  sync_reps = '0;
    logic [15:0] payload_len = '0;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    prbs_frame_ctrl_if u_if();

    prbs_frame_ctrl dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .start       (start),
        .abort       (abort),
        .sync_reps   (sync_reps),
        .payload_len (payload_len),
        .stream      (u_if.master),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: header bytes, then a PRBS15 bit stream packed MSB-first into bytes.
    task automatic model_frame(input int reps, input int len);
        int s;
        int b;
        int fb;
        int x;
        exp_q.delete();
        s = 'h7FFF;
        x = 0;
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back(8'((PAT >> (24 - 8 * k)) & 32'hFF));
        for (int n = 0; n < len; n++) begin
            b = 0;
            for (int j = 0; j < 8; j++) begin
                fb = ((s >> 14) ^ (s >> 13)) & 1;
                s  = ((s << 1) | fb) & 'h7FFF;
                b  = (b << 1) | fb;
            end
            exp_q.push_back(8'(b));
            x = x ^ b;
        end
`ifdef PRBS_FRAME_CHK_EN
        exp_q.push_back(8'(x));
`endif
    endtask

    // mode: 0 ready always, 1 ready toggles, 2 ready random.
    task automatic run_frame(input int reps, input int len, input int mode,
                             input int abort_after, input bit poke_start);
        int   cyc;
        int   acc_n;
        int   last_acc;
        int   budget;
        bit   stalled;
        bit   done_seen;
        bit   fin;
        logic [7:0] held;

        model_frame(reps, len);
        budget    = 4 * (4 * reps + len) + 40;
        acc_n     = 0;
        last_acc  = 0;
        stalled   = 0;
        done_seen = 0;
        fin       = 0;
        held      = '0;

        @(posedge CLK); #1;
        sync_reps      = 8'(reps);
        payload_len    = 16'(len);
        start          = 1'b1;
        u_if.out_ready = 1'b1;
        @(posedge CLK); #1;
        start       = 1'b0;
        sync_reps   = 8'($urandom);
        payload_len = 16'($urandom);
        cyc = 1;
        chk("first_valid", u_if.out_valid, exp_q.size() != 0);

        while (cyc <= budget) begin
            if (done_seen) begin
                chk("done_pulse", done, 0);
                chk("busy_after", busy, 0);
                fin = 1;
                break;
            end
            if (stalled) begin
                chk("stall_valid", u_if.out_valid, 1);
                chk("stall_data", u_if.out_data, held);
            end
            chk("busy", busy, 1);
            if (exp_q.size() == 0) chk("idle_valid", u_if.out_valid, 0);
            if (done) begin
                chk("done_when", cyc, last_acc + 2);
                chk("bytes_left", exp_q.size(), 0);
                done_seen = 1;
            end

            case (mode)
                0:       u_if.out_ready = 1'b1;
                1:       u_if.out_ready = cyc[0];
                default: u_if.out_ready = 1'($urandom);
            endcase
            start = poke_start && (cyc == 3);
            if (start) begin
                sync_reps   = 8'($urandom);
                payload_len = 16'($urandom);
            end

            if (abort_after >= 0 && acc_n == abort_after) begin
                abort = 1'b1;
                u_if.out_ready = 1'b0;
                @(posedge CLK); #1;
                abort = 1'b0;
                chk("abort_valid", u_if.out_valid, 0);
                chk("abort_busy", busy, 0);
                for (int i = 0; i < 3; i++) begin
                    chk("abort_no_done", done, 0);
                    @(posedge CLK); #1;
                end
                exp_q.delete();
                fin = 1;
                break;
            end

            if (u_if.out_valid && u_if.out_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", u_if.out_data, 32'hFFFF_FFFF);
                else chk("byte", u_if.out_data, exp_q.pop_front());
                acc_n++;
                last_acc = cyc;
            end else if (mode == 0 && exp_q.size() != 0) begin
                chk("no_bubble", u_if.out_valid, 1);
            end
            stalled = u_if.out_valid && !u_if.out_ready;
            held    = u_if.out_data;

            @(posedge CLK); #1;
            start = 1'b0;
            cyc++;
        end
        chk("frame_timeout", fin, 1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        u_if.out_ready = 1'b0;
        #3;
        chk("rst_valid", u_if.out_valid, 0);
        chk("rst_data", u_if.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge CLK); #2;
        RSTn = 1'b1;

        // abort beats start in IDLE
        @(posedge CLK); #1;
        sync_reps = 8'd1; payload_len = 16'd2; start = 1'b1; abort = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_valid", u_if.out_valid, 0);

        run_frame(1, 2, 0, -1, 0);
        run_frame(1, 2, 1, -1, 0);
        run_frame(0, 3, 0, -1, 0);
        run_frame(2, 0, 0, -1, 0);
        run_frame(0, 0, 0, -1, 0);
        run_frame(0, 2, 0, -1, 0);
        run_frame(1, 2, 0, 2, 0);
        run_frame(1, 2, 0, -1, 0);

        // asynchronous reset in the middle of the payload
        @(posedge CLK); #1;
        sync_reps = 8'd0; payload_len = 16'd40; start = 1'b1; u_if.out_ready = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #3;
        RSTn = 1'b0;
        #1;
        chk("midrst_valid", u_if.out_valid, 0);
        chk("midrst_data", u_if.out_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        repeat (2) @(posedge CLK);
        #2;
        RSTn = 1'b1;
        run_frame(1, 2, 0, -1, 0);

        run_frame(2, 10, 0, -1, 1);
        for (int i = 0; i < 12; i++)
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), 2, -1, 0);
        run_frame(255, 5, 1, -1, 0);
        run_frame(0, 65535, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs_frame_ctrl.md
Name: prbs_frame_ctrl

Overview:
- Sequencer that builds test frames for the PRBS link and feeds them to the byte-wide stream checked by the downstream pattern detector.
- Each frame is a sync header followed by a PRBS15 payload. The header is the 32-bit sync pattern repeated sync_reps times, MSB byte first.
- Delivers bytes over a valid/ready handshake; host control is start/abort with busy/done status.

Parameters:
- PATTERN, 32'hAABBCCDD: sync word; sent as bytes [31:24], [23:16], [15:8], [7:0].
- SEED, 15'h7FFF: PRBS15 LFSR reload value; must be non-zero.

Ports:
- CLK  input  1  clock
- RSTn  input  1  reset, asynchronous, active-low
- start  input  1  begin a frame; sampled only in IDLE
- abort  input  1  terminate the frame in progress
- sync_reps  input  8  number of PATTERN repetitions in the header; latched on start
- payload_len  input  16  number of payload bytes; latched on start
- out_data  output  8  stream byte
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts the byte this cycle
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse when a frame completes normally

Behaviour:
- Reset: state IDLE; out_data=0, out_valid=0, busy=0, done=0; counters=0; LFSR=SEED. Reset is effective immediately, including mid-frame; no done is produced.
- All outputs are registered.
- A byte transfers only on a cycle where out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_data must stay stable and out_valid must stay high.
- State IDLE:
  - start=1 latches sync_reps and payload_len, reloads the LFSR with SEED and sets busy=1.
  - Next state is SYNC if sync_reps!=0, else PAYLOAD if payload_len!=0, else FINISH.
  - The first byte is valid the cycle after start (1-cycle latency).
- State SYNC:
  - Emits PATTERN bytes in order, using a 2-bit byte index and an 8-bit repetition counter.
  - After the 4th byte of repetition sync_reps is accepted, go to PAYLOAD if payload_len!=0, else FINISH.
  - Byte transfers are back-to-back: no bubble between bytes or states while out_ready=1.
- State PAYLOAD:
  - Each byte is 8 serial LFSR steps computed in one cycle.
  - Each step: fb = s[14]^s[13]; s = {s[13:0], fb}.
  - The output bits are the fb values; the first step forms out_data[7].
  - The LFSR advances only when a payload byte is accepted.
  - The 16-bit byte counter ends the state after payload_len accepted bytes.
- State FINISH:
  - out_valid=0, done=1 for exactly one cycle, busy=0 from the following cycle, then IDLE.
  - A start in that following cycle is accepted.
- start while busy is ignored. Config inputs changing mid-frame have no effect.
- abort (any state except IDLE): next cycle out_valid=0, busy=0, state IDLE, no done pulse. A pending unaccepted byte is dropped.
- abort and start in the same IDLE cycle: abort wins, frame not started.
- Counter boundaries: sync_reps=255 produces 1020 header bytes. payload_len=65535 produces 65535 bytes with no counter wrap misbehaviour.

Optional Feature:
- Macro: PRBS_FRAME_CHK_EN.
- Defined:
  - After the payload, state CHK emits one extra byte equal to the XOR of all accepted payload bytes, then FINISH.
  - If payload_len=0, the checksum byte is 8'h00.
  - The checksum accumulator clears on start and on abort.
- Undefined: no CHK state and no accumulator logic; the frame ends after the payload.

Test Plan:
- Basic frame: sync_reps=1, payload_len=2, out_ready=1 constantly, start pulse.
  - Bytes AA, BB, CC, DD, 00, 02 on consecutive cycles starting 1 cycle after start.
  - done pulses once after the last byte; busy=1 throughout the frame.
- Backpressure: same frame with out_ready toggled 1/0 every cycle.
  - Identical byte sequence; out_data stable during every stall.
  - LFSR not advanced on stalled cycles.
- Empty sections:
  - sync_reps=0, payload_len=3 → payload bytes 00, 02, then the next golden-model byte.
  - sync_reps=2, payload_len=0 → AA BB CC DD AA BB CC DD, then done.
  - Both zero → no valid bytes, done 2 cycles after start.
- Abort: abort asserted in SYNC after the 2nd byte.
  - out_valid=0 the next cycle, no done.
  - A new start then begins again from AA and LFSR=SEED (payload begins 00, 02).
- Reset mid-payload: RSTn low asynchronously → all outputs 0 immediately, state IDLE.
  - Start ignored while busy: a second start mid-frame does not alter the stream.
- With PRBS_FRAME_CHK_EN defined:
  - sync_reps=0, payload_len=2 → bytes 00, 02, 02.
  - payload_len=0 → single byte 00, then done.
